// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** DEF_ADDR_W;
    localparam int REG_ZERO   = 0;

    // Index of a writeback requester (0 = ALU path, 1 = load/multiply path)
    typedef logic req_idx_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; under
// contention the requester that did not win last time is granted.
// last_grant resets to 1 so requester 0 wins the first contention.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_idx_t last_grant;

    // One-hot grant from current requests and the last winner
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'b0) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner; idle cycles leave the pointer alone
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (|valid)
            last_grant <= req_idx_t'(grant[1]);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin between two writeback
// requesters, one registered output stage feeding the file's write port,
// and a per-register busy scoreboard for decode stalls.
// Optional build macro WB_ZERO_DROP_EN: writes to register 0 are still
// acknowledged but never raise rf_we.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic [DATA_W-1:0]    req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_W-1:0]    req1_addr,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 req1_ready,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_addr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [2**ADDR_W-1:0] busy_mask
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [1:0]        grant;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              we_next;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    // The output stage never stalls, so ready is simply the grant
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign any_grant  = |grant;

    // Mux the granted requester's payload toward the output register
    always_comb begin
        sel_addr = grant[1] ? req1_addr : req0_addr;
        sel_data = grant[1] ? req1_data : req0_data;
`ifdef WB_ZERO_DROP_EN
        we_next  = any_grant && (sel_addr != ADDR_W'(REG_ZERO));
`else
        we_next  = any_grant;
`endif
    end

    // Output register; address/data hold when nothing is granted
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= we_next;
            if (any_grant) begin
                rf_addr  <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // Scoreboard next state: a new issue beats a retiring write to the
    // same register, since the old write no longer covers the new result
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (issue_valid && issue_addr == ADDR_W'(r))
                busy_d[r] = 1'b1;
            else if (rf_we && rf_addr == ADDR_W'(r))
                busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state; register 0 is never tracked
    always_ff @(posedge clk) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_mask = busy_q;

endmodule
